// File: rtl/led_status_engine.sv
// Front-panel LED driver: per-channel level/blink/flash/cylon modes with global PWM dimming
// and an error override that replaces every output with an alternating blink pattern.
module led_status_engine #(
    parameter int NUM_LEDS       = 16,
    parameter int BLINK_DIV_BITS = 21,
    parameter int FLASH_ON       = 4000000,
    parameter int FLASH_OFF      = 2000000,
    parameter int CYLON_DIV_BITS = 20,
    parameter int PWM_BITS       = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [2*NUM_LEDS-1:0]       mode_i,
    input  logic [NUM_LEDS-1:0]         level_i,
    input  logic [NUM_LEDS-1:0]         event_i,
    input  logic [PWM_BITS-1:0]         brightness_i,
    input  logic                        err_i,
    output logic                        blink_o,
    output logic [$clog2(NUM_LEDS)-1:0] cylon_pos_o,
    output logic [NUM_LEDS-1:0]         led_o
);

    // Flash FSM, one per channel:
    //   state | meaning
    //   IDLE  | dark, waiting for an event
    //   ON    | lit for FLASH_ON cycles, events ignored
    //   OFF   | dark for FLASH_OFF cycles, events latched into pending
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } flash_state_t;

    localparam int POS_W  = $clog2(NUM_LEDS);
    localparam int FMAX   = (FLASH_ON > FLASH_OFF) ? FLASH_ON : FLASH_OFF;
    localparam int FCNT_W = (FMAX > 1) ? $clog2(FMAX) : 1;

    localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
    localparam logic [FCNT_W-1:0] ON_LOAD  = FCNT_W'(FLASH_ON - 1);
    localparam logic [FCNT_W-1:0] OFF_LOAD = FCNT_W'(FLASH_OFF - 1);

    logic [BLINK_DIV_BITS-1:0] r_blink_cnt;
    logic                      r_blink;
    logic [CYLON_DIV_BITS-1:0] r_cyl_pre;
    logic [POS_W-1:0]          r_pos;
    logic                      r_dir_up;
    logic [PWM_BITS-1:0]       r_pwm_cnt;
    logic [NUM_LEDS-1:0]       r_led;

    flash_state_t        r_state     [NUM_LEDS];
    flash_state_t        w_state_nxt [NUM_LEDS];
    logic [FCNT_W-1:0]   r_fcnt      [NUM_LEDS];
    logic [FCNT_W-1:0]   w_fcnt_nxt  [NUM_LEDS];
    logic [NUM_LEDS-1:0] r_pend;
    logic [NUM_LEDS-1:0] w_pend_nxt;

    logic                w_pwm_en;
    logic [NUM_LEDS-1:0] w_flash;
    logic [NUM_LEDS-1:0] w_raw;
    logic [NUM_LEDS-1:0] w_led_nxt;

    assign blink_o     = r_blink;
    assign cylon_pos_o = r_pos;
    assign led_o       = r_led;
    assign w_pwm_en    = (&brightness_i) | (r_pwm_cnt < brightness_i);

    always_comb begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_fcnt_nxt[i]  = r_fcnt[i];
            w_pend_nxt[i]  = r_pend[i];
            case (r_state[i])
                S_IDLE: begin
                    if (event_i[i]) begin
                        w_state_nxt[i] = S_ON;
                        w_fcnt_nxt[i]  = ON_LOAD;
                    end
                end
                S_ON: begin
                    if (r_fcnt[i] == '0) begin
                        w_state_nxt[i] = S_OFF;
                        w_fcnt_nxt[i]  = OFF_LOAD;
                    end else begin
                        w_fcnt_nxt[i] = r_fcnt[i] - 1'b1;
                    end
                end
                S_OFF: begin
                    if (r_fcnt[i] == '0) begin
                        // An event arriving on the final dark cycle counts as pending.
                        w_state_nxt[i] = (r_pend[i] | event_i[i]) ? S_ON : S_IDLE;
                        w_fcnt_nxt[i]  = (r_pend[i] | event_i[i]) ? ON_LOAD : '0;
                        w_pend_nxt[i]  = 1'b0;
                    end else begin
                        w_fcnt_nxt[i] = r_fcnt[i] - 1'b1;
                        if (event_i[i]) begin
                            w_pend_nxt[i] = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                    w_fcnt_nxt[i]  = '0;
                    w_pend_nxt[i]  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_flash   = '0;
        w_raw     = '0;
        w_led_nxt = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_flash[i] = (w_state_nxt[i] == S_ON);
            case (mode_i[2*i +: 2])
                2'd0:    w_raw[i] = level_i[i];
                2'd1:    w_raw[i] = level_i[i] & r_blink;
                2'd2:    w_raw[i] = w_flash[i];
                default: w_raw[i] = (r_pos == POS_W'(i));
            endcase
            w_led_nxt[i] = err_i ? (r_blink ^ ((i % 2) == 1)) : (w_raw[i] & w_pwm_en);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
            r_cyl_pre   <= '0;
            r_pos       <= '0;
            r_dir_up    <= 1'b1;
            r_pwm_cnt   <= '0;
            r_pend      <= '0;
            r_led       <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_state[i] <= S_IDLE;
                r_fcnt[i]  <= '0;
            end
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
            if (&r_blink_cnt) begin
                r_blink <= ~r_blink;
            end
            r_cyl_pre <= r_cyl_pre + 1'b1;
            // Bounce without dwelling on the endpoints: flip direction as the end is reached.
            if (&r_cyl_pre) begin
                if (r_dir_up) begin
                    r_pos <= r_pos + 1'b1;
                    if (r_pos == POS_MAX - 1'b1) begin
                        r_dir_up <= 1'b0;
                    end
                end else begin
                    r_pos <= r_pos - 1'b1;
                    if (r_pos == POS_ONE) begin
                        r_dir_up <= 1'b1;
                    end
                end
            end
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_pend    <= w_pend_nxt;
            r_led     <= w_led_nxt;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_fcnt[i]  <= w_fcnt_nxt[i];
            end
        end
    end

endmodule
